// File: rtl/npx_pkg.sv
// Shared types and constants for the NeoPixel update scheduler.
package npx_pkg;
  localparam int NUM_NPX_DEFAULT = 17;
  localparam int PIX_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    GO,
    HOLD,
    BUSY
  } sched_state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter; tick is high during the cycle in which the count wraps.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);
endmodule

// File: rtl/npx_scheduler.sv
// Two-player pixel update scheduler with round-robin arbitration and frame-rate refresh.
// Define NPX_SCHED_AUTOREFRESH_EN to request a strand refresh on every tick.
module npx_scheduler
  import npx_pkg::*;
#(
  parameter int NUM_NPX      = NUM_NPX_DEFAULT,
  parameter int FRAME_CYCLES = 833333
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0][PIX_W-1:0] req_pixel,
  input  logic [1:0][23:0]      req_rgb,
  output logic [1:0]            req_ack,
  input  logic                  npx_ready,
  output logic                  npx_load,
  output logic                  npx_go,
  output logic [PIX_W-1:0]      npx_pixel,
  output logic [7:0]            npx_red,
  output logic [7:0]            npx_green,
  output logic [7:0]            npx_blue,
  output logic                  err_oob,
  output sched_state_t          dbg_state
);
  // Handshake: a requester holds req_valid with its payload until it sees req_ack
  // for one cycle; the ack cycle is the transfer. Loads reach the controller only
  // in LOADING with npx_ready high, and a pending refresh blocks new grants.
`ifdef NPX_SCHED_AUTOREFRESH_EN
  localparam bit AUTO_REFRESH = 1'b1;
`else
  localparam bit AUTO_REFRESH = 1'b0;
`endif
  localparam logic [PIX_W:0] LIMIT = (PIX_W + 1)'(NUM_NPX);

  sched_state_t state, state_next;
  logic dirty, send_pend, last_grant, busy_guard, tick;
  logic grant, gsel, in_range;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    grant = 1'b0;
    gsel  = 1'b0;
    if (state == LOADING && npx_ready && !send_pend && (req_valid != 2'b00)) begin
      grant = 1'b1;
      gsel  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    end
    in_range = ({1'b0, req_pixel[gsel]} < LIMIT);
  end

  always_comb begin
    req_ack   = 2'b00;
    npx_load  = 1'b0;
    npx_pixel = '0;
    npx_red   = 8'h00;
    npx_green = 8'h00;
    npx_blue  = 8'h00;
    if (grant) begin
      req_ack[gsel] = 1'b1;
      if (in_range) begin
        npx_load  = 1'b1;
        npx_pixel = req_pixel[gsel];
        {npx_red, npx_green, npx_blue} = req_rgb[gsel];
      end
    end
    npx_go = (state == GO);
  end

  // busy_guard masks ready in the first BUSY cycle; together with HOLD this
  // covers the two cycles the controller needs to drop ready after go.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (npx_ready) state_next = LOADING;
      LOADING: if (send_pend && !grant) state_next = GO;
      GO:      state_next = HOLD;
      HOLD:    state_next = BUSY;
      BUSY:    if (!busy_guard && npx_ready) state_next = LOADING;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dirty      <= 1'b0;
      send_pend  <= 1'b0;
      last_grant <= 1'b1;
      busy_guard <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      state      <= state_next;
      busy_guard <= (state == HOLD);
      if (grant) last_grant <= gsel;
      if (grant && !in_range) err_oob <= 1'b1;
      if (state == GO) begin
        dirty     <= 1'b0;
        send_pend <= tick && AUTO_REFRESH;
      end else begin
        if (npx_load) dirty <= 1'b1;
        // A load landing on the tick cycle is part of the frame it precedes.
        if (tick && (dirty || npx_load || AUTO_REFRESH)) send_pend <= 1'b1;
      end
    end
  end

  assign dbg_state = state;
endmodule
